uart_tx_fifo_ctrl: RTL

Transmit-side front end for the UART transmitter. It buffers parallel bytes from the system in a small synchronous FIFO. It pops one byte at a time into the transmitter's parallel-data/data-valid inputs, pacing itself on the transmitter's busy output. It runs in the TX clock domain and connects directly to the transmitter's P_DATA, Data_Valid and busy pins.

---
 rtl/uart_tx_fifo_ctrl_if.sv | 26 ++
 rtl/uart_tx_fifo_ctrl.sv | 65 ++++++
 2 files changed

// File: rtl/uart_tx_fifo_ctrl_if.sv
// uart_tx_fifo_ctrl_if: system write port and UART transmitter pins of the TX FIFO front end
//   master: system/transmitter side (drives WR_DATA, WR_EN, CLR_OVF, TX_BUSY)
//   slave : FIFO controller (drives FULL, EMPTY, COUNT, OVERFLOW, TX_P_DATA, TX_DATA_VALID)
interface uart_tx_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  WR_EN;
  logic                  CLR_OVF;
  logic                  FULL;
  logic                  EMPTY;
  logic [ADDR_WIDTH:0]   COUNT;
  logic                  OVERFLOW;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_DATA_VALID;
  logic                  TX_BUSY;
  modport master (
    output WR_DATA, WR_EN, CLR_OVF, TX_BUSY,
    input  FULL, EMPTY, COUNT, OVERFLOW, TX_P_DATA, TX_DATA_VALID
  );
  modport slave (
    input  WR_DATA, WR_EN, CLR_OVF, TX_BUSY,
    output FULL, EMPTY, COUNT, OVERFLOW, TX_P_DATA, TX_DATA_VALID
  );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: byte FIFO feeding a UART transmitter, one Data_Valid pulse per word paced by busy
//   CLK : TX clock
//   RST : asynchronous active-low reset (storage array is not reset)
//   bus : slave side of uart_tx_fifo_ctrl_if (write port, status, transmitter pins)
module uart_tx_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic               CLK,
  input logic               RST,
  uart_tx_fifo_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [1:0]            state, state_nx;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  valid, ovf, full, empty, wr_ok, pop, go;
  assign full  = count == (ADDR_WIDTH+1)'(DEPTH);
  assign empty = count == '0;
  // write acceptance uses pre-edge FULL, so a pop on the same edge does not rescue it
  assign wr_ok = bus.WR_EN && !full;
  // the pop is committed on the edge that leaves LOAD
  assign pop   = state == LOAD;
  assign go    = state == IDLE && !empty && !bus.TX_BUSY;
  always_comb begin
    state_nx = state == IDLE      ? (go ? LOAD : IDLE) :
               state == LOAD      ? WAIT_BUSY :
               state == WAIT_BUSY ? (bus.TX_BUSY ? WAIT_DONE : WAIT_BUSY) :
                                    (bus.TX_BUSY ? WAIT_DONE : IDLE);
  end
  always_ff @(posedge CLK)
    if (wr_ok) mem[wr_ptr] <= bus.WR_DATA;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      valid  <= 1'b0;
      p_data <= '0;
    end else begin
      state <= state_nx;
      count <= count + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(pop);
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      // a rejected write outranks a clear on the same edge
      ovf   <= (bus.WR_EN && full) || (ovf && !bus.CLR_OVF);
      valid <= go;
      if (go) p_data <= mem[rd_ptr];
    end
  end
  assign bus.FULL          = full;
  assign bus.EMPTY         = empty;
  assign bus.COUNT         = count;
  assign bus.OVERFLOW      = ovf;
  assign bus.TX_P_DATA     = p_data;
  assign bus.TX_DATA_VALID = valid;
endmodule
